// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_fwd_unit: N-stage operand forwarding, load-use detection and an
// optional mul/div scoreboard (HAZARD_MC_SCOREBOARD_EN).  Rev 1.0
// ---------------------------------------------------------------------------
module hazard_fwd_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_STAGES = 2,
  parameter int MC_LAT     = 4,
  localparam int SEL_W     = $clog2(NUM_STAGES + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           id_valid,
  input  logic [REG_ADDR_W-1:0]          id_rs,
  input  logic [REG_ADDR_W-1:0]          id_rt,
  input  logic                           id_is_mc,
  input  logic [REG_ADDR_W-1:0]          ex_rs,
  input  logic [REG_ADDR_W-1:0]          ex_rt,
  input  logic                           ex_mem_read,
  input  logic [REG_ADDR_W-1:0]          ex_waddr,
  input  logic [NUM_STAGES-1:0]          stage_reg_write,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] stage_waddr,
  input  logic                           mc_start,
  input  logic [REG_ADDR_W-1:0]          mc_waddr,
  output logic [SEL_W-1:0]               alu_op_1_ctrl,
  output logic [SEL_W-1:0]               alu_op_2_ctrl,
  output logic                           stall,
  output logic                           bubble,
  output logic                           mc_busy,
  output logic                           mc_done
);

  logic [SEL_W-1:0] w_sel_1;
  logic [SEL_W-1:0] w_sel_2;
  logic             w_load_use;
  logic             w_mc_busy;
  logic             w_mc_done;
  logic             w_mc_raw;
  logic             w_mc_struct;
  logic             w_hazard;

  // Walk oldest to youngest so the youngest matching stage wins.
  always_comb begin
    w_sel_1 = '0;
    w_sel_2 = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (stage_reg_write[k] && (ex_rs != '0) &&
          (stage_waddr[k*REG_ADDR_W +: REG_ADDR_W] == ex_rs))
        w_sel_1 = SEL_W'(k + 1);
      if (stage_reg_write[k] && (ex_rt != '0) &&
          (stage_waddr[k*REG_ADDR_W +: REG_ADDR_W] == ex_rt))
        w_sel_2 = SEL_W'(k + 1);
    end
  end

  assign w_load_use = id_valid && ex_mem_read && (ex_waddr != '0) &&
                      ((ex_waddr == id_rs) || (ex_waddr == id_rt));

`ifdef HAZARD_MC_SCOREBOARD_EN
  localparam int       CNT_W  = $clog2(MC_LAT);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] dst_q, dst_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    case (state_q)
      S_IDLE: begin
        if (mc_start) begin
          state_d = S_BUSY;
          dst_d   = mc_waddr;
          cnt_d   = CNT_W'(MC_LAT - 1);
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
    end
  end

  assign w_mc_busy   = (state_q == S_BUSY);
  assign w_mc_done   = w_mc_busy && (cnt_q == '0);
  // The result is written at the end of the done cycle, so RAW holds through it.
  assign w_mc_raw    = w_mc_busy && id_valid && (dst_q != '0) &&
                       ((dst_q == id_rs) || (dst_q == id_rt));
  assign w_mc_struct = w_mc_busy && id_valid && id_is_mc;
`else
  logic unused_mc_inputs;
  assign unused_mc_inputs = ^{id_is_mc, mc_start, mc_waddr, clk};
  assign w_mc_busy   = 1'b0;
  assign w_mc_done   = 1'b0;
  assign w_mc_raw    = 1'b0;
  assign w_mc_struct = 1'b0;
`endif

  assign w_hazard = w_load_use || w_mc_raw || w_mc_struct;

  assign alu_op_1_ctrl = rst_n ? w_sel_1 : '0;
  assign alu_op_2_ctrl = rst_n ? w_sel_2 : '0;
  assign stall         = rst_n && w_hazard;
  assign bubble        = rst_n && w_hazard;
  assign mc_busy       = rst_n && w_mc_busy;
  assign mc_done       = rst_n && w_mc_done;

endmodule
`default_nettype wire
